// File: rtl/wrap_monitor_if.sv
// Bus between an up/down counter observer and wrap_monitor: sampled counter
// inputs plus the monitor's registered event/status outputs.
interface wrap_monitor_if #(
    parameter int WRAP_W = 8
);
    logic              sample_en;
    logic [2:0]        count_in;
    logic              M;
    logic              clr;
    logic              wrap_up;
    logic              wrap_down;
    logic [WRAP_W-1:0] wrap_count;
    logic [2:0]        last_count;
    logic              step_err;

    modport master (
        output sample_en, count_in, M, clr,
        input  wrap_up, wrap_down, wrap_count, last_count, step_err
    );

    modport slave (
        input  sample_en, count_in, M, clr,
        output wrap_up, wrap_down, wrap_count, last_count, step_err
    );
endinterface

// File: rtl/wrap_monitor.sv
// Watches a 3-bit up/down counter, pulses on 7->0 / 0->7 wraps and keeps a
// saturating net wrap tally. Optional step checking: WRAP_MONITOR_STEP_CHECK_EN.
module wrap_monitor #(
    parameter int WRAP_W = 8
) (
    input logic           clock,
    input logic           reset_n,
    wrap_monitor_if.slave mon
);
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_t;

    localparam logic [WRAP_W-1:0] CNT_MAX = {WRAP_W{1'b1}};
    localparam logic [WRAP_W-1:0] CNT_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};

    state_t            state_r, state_s;
    logic [2:0]        last_count_r, last_count_s;
    logic              wrap_up_r, wrap_up_s;
    logic              wrap_down_r, wrap_down_s;
    logic [WRAP_W-1:0] wrap_count_r, wrap_count_s;
    logic              track_sample_s;

    // Next-state, pulse, last-sample and tally logic
    always_comb begin
        state_s        = state_r;
        last_count_s   = last_count_r;
        wrap_up_s      = 1'b0;
        wrap_down_s    = 1'b0;
        wrap_count_s   = wrap_count_r;
        track_sample_s = 1'b0;

        case (state_r)
            IDLE: begin
                if (mon.sample_en) begin
                    last_count_s = mon.count_in;
                    state_s      = TRACK;
                end else begin
                    state_s      = IDLE;
                end
            end
            TRACK: begin
                if (mon.sample_en) begin
                    track_sample_s = 1'b1;
                    last_count_s   = mon.count_in;
                    if ((last_count_r == 3'd7) && (mon.count_in == 3'd0) && mon.M) begin
                        wrap_up_s = 1'b1;
                    end else if ((last_count_r == 3'd0) && (mon.count_in == 3'd7) && !mon.M) begin
                        wrap_down_s = 1'b1;
                    end else begin
                        wrap_up_s   = 1'b0;
                        wrap_down_s = 1'b0;
                    end
                end else begin
                    track_sample_s = 1'b0;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // Clear has priority over any tally movement, but the pulse still issues
        if (mon.clr) begin
            wrap_count_s = {WRAP_W{1'b0}};
        end else if (wrap_up_s && (wrap_count_r != CNT_MAX)) begin
            wrap_count_s = wrap_count_r + CNT_ONE;
        end else if (wrap_down_s && (wrap_count_r != {WRAP_W{1'b0}})) begin
            wrap_count_s = wrap_count_r - CNT_ONE;
        end else begin
            wrap_count_s = wrap_count_r;
        end
    end

    // State and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            last_count_r <= 3'd0;
            wrap_up_r    <= 1'b0;
            wrap_down_r  <= 1'b0;
            wrap_count_r <= {WRAP_W{1'b0}};
        end else begin
            state_r      <= state_s;
            last_count_r <= last_count_s;
            wrap_up_r    <= wrap_up_s;
            wrap_down_r  <= wrap_down_s;
            wrap_count_r <= wrap_count_s;
        end
    end

`ifdef WRAP_MONITOR_STEP_CHECK_EN
    logic step_err_r, step_err_s;

    // A legal step is a hold or a single step in the direction given by M
    function automatic logic step_illegal(input logic [2:0] prev,
                                          input logic [2:0] cur,
                                          input logic       m);
        logic result;
        if (cur == prev) begin
            result = 1'b0;
        end else if (cur == (prev + 3'd1)) begin
            result = !m;
        end else if (cur == (prev - 3'd1)) begin
            result = m;
        end else begin
            result = 1'b1;
        end
        return result;
    endfunction

    // Sticky error flag, cleared only by clr
    always_comb begin
        step_err_s = step_err_r;
        if (mon.clr) begin
            step_err_s = 1'b0;
        end else if (track_sample_s && step_illegal(last_count_r, mon.count_in, mon.M)) begin
            step_err_s = 1'b1;
        end else begin
            step_err_s = step_err_r;
        end
    end

    // Step error register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            step_err_r <= 1'b0;
        end else begin
            step_err_r <= step_err_s;
        end
    end

    assign mon.step_err = step_err_r;
`else
    logic unused_track_s;
    assign unused_track_s = track_sample_s;
    assign mon.step_err   = 1'b0;
`endif

    assign mon.wrap_up    = wrap_up_r;
    assign mon.wrap_down  = wrap_down_r;
    assign mon.wrap_count = wrap_count_r;
    assign mon.last_count = last_count_r;
endmodule

// File: tb/tb_wrap_monitor.sv
// Scoreboard bench for wrap_monitor: an 8-bit and a 2-bit tally instance share
// one directed stimulus stream; expectations are queued and checked per cycle.
module tb_wrap_monitor;
`ifdef WRAP_MONITOR_STEP_CHECK_EN
    localparam bit STEP_ON = 1'b1;
`else
    localparam bit STEP_ON = 1'b0;
`endif

    typedef struct {
        string      name;
        logic       up;
        logic       dn;
        logic [7:0] cnt8;
        logic [1:0] cnt2;
        logic [2:0] last;
        logic       err;
    } exp_t;

    logic clock;
    logic reset_n;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    wrap_monitor_if #(.WRAP_W(8)) bus8 ();
    wrap_monitor_if #(.WRAP_W(2)) bus2 ();

    wrap_monitor #(.WRAP_W(8)) dut8 (.clock(clock), .reset_n(reset_n), .mon(bus8));
    wrap_monitor #(.WRAP_W(2)) dut2 (.clock(clock), .reset_n(reset_n), .mon(bus2));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: compares both instances against the oldest queued expectation
    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (bus8.wrap_up !== e.up || bus8.wrap_down !== e.dn ||
                bus8.wrap_count !== e.cnt8 || bus8.last_count !== e.last ||
                bus8.step_err !== e.err || bus2.wrap_up !== e.up ||
                bus2.wrap_down !== e.dn || bus2.wrap_count !== e.cnt2 ||
                bus2.last_count !== e.last || bus2.step_err !== e.err) begin
                errors++;
                $display("FAIL %s: got up=%b/%b dn=%b/%b cnt=%0d/%0d last=%0d/%0d err=%b/%b, expected up=%b dn=%b cnt=%0d/%0d last=%0d err=%b",
                         e.name, bus8.wrap_up, bus2.wrap_up, bus8.wrap_down, bus2.wrap_down,
                         bus8.wrap_count, bus2.wrap_count, bus8.last_count, bus2.last_count,
                         bus8.step_err, bus2.step_err, e.up, e.dn, e.cnt8, e.cnt2, e.last, e.err);
            end
        end
    end

    task automatic step(input string nm, input logic en, input logic [2:0] c,
                        input logic m, input logic cl, input logic eu, input logic ed,
                        input logic [7:0] e8, input logic [1:0] e2,
                        input logic [2:0] el, input logic ee);
        exp_t e;
        bus8.sample_en = en; bus8.count_in = c; bus8.M = m; bus8.clr = cl;
        bus2.sample_en = en; bus2.count_in = c; bus2.M = m; bus2.clr = cl;
        @(posedge clock);
        e.name = nm; e.up = eu; e.dn = ed; e.cnt8 = e8; e.cnt2 = e2;
        e.last = el; e.err = ee & STEP_ON;
        exp_q.push_back(e);
        @(negedge clock);
    endtask

    task automatic do_reset(input string nm);
        reset_n = 1'b0;
        step(nm, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 3'd0, 1'b0);
        step(nm, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 3'd0, 1'b0);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] n2;
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        bus8.sample_en = 1'b0; bus8.count_in = 3'd0; bus8.M = 1'b0; bus8.clr = 1'b0;
        bus2.sample_en = 1'b0; bus2.count_in = 3'd0; bus2.M = 1'b0; bus2.clr = 1'b0;
        @(negedge clock);
        do_reset("reset_state");

        // Up count 0..7 then 0: one up wrap
        step("idle_load", 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 3'd0, 1'b0);
        for (int v = 1; v <= 7; v++)
            step("up_track", 1'b1, 3'(v), 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 3'(v), 1'b0);
        step("up_wrap", 1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 2'd1, 3'd0, 1'b0);
        step("en_low_hold", 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 2'd1, 3'd0, 1'b0);
        step("same_value", 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 2'd1, 3'd0, 1'b0);

        // Mid-operation reset, then down count 3,2,1,0,7
        do_reset("reset_mid");
        step("dn_load", 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 3'd3, 1'b0);
        step("dn_2", 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 3'd2, 1'b0);
        step("dn_1", 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 3'd1, 1'b0);
        step("dn_0", 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 3'd0, 1'b0);
        step("dn_wrap_sat0", 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 2'd0, 3'd7, 1'b0);
        step("dn_pulse_end", 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 3'd7, 1'b0);

        // Four up wraps: wide tally 1..4, narrow tally 1,2,3,3
        for (int w = 1; w <= 4; w++) begin
            n2 = (w > 3) ? 2'd3 : 2'(w);
            step("multi_wrap", 1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'(w), n2, 3'd0, 1'b0);
            for (int v = 1; v <= 7; v++)
                step("multi_track", 1'b1, 3'(v), 1'b1, 1'b0, 1'b0, 1'b0, 8'(w), n2, 3'(v), 1'b0);
        end
        step("wrap5", 1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd5, 2'd3, 3'd0, 1'b0);
        step("dn_decrement", 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 2'd2, 3'd7, 1'b0);
        step("dn_step", 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4, 2'd2, 3'd6, 1'b0);
        step("up_step", 1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4, 2'd2, 3'd7, 1'b0);
        step("wrap_to5", 1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd5, 2'd3, 3'd0, 1'b0);
        for (int v = 1; v <= 7; v++)
            step("pre_clr_track", 1'b1, 3'(v), 1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 2'd3, 3'(v), 1'b0);
        step("clr_with_wrap", 1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 2'd0, 3'd0, 1'b0);

        // Illegal steps 2 -> 5 and 5 -> 4 with M=1
        do_reset("reset_err");
        step("err_load", 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 3'd2, 1'b0);
        step("err_jump", 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 3'd5, 1'b1);
        step("err_sticky", 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 3'd5, 1'b1);
        step("err_clr", 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 2'd0, 3'd5, 1'b0);
        step("err_wrong_dir", 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 3'd4, 1'b1);
        step("err_clr2", 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 2'd0, 3'd4, 1'b0);

        // Reset between samples 7 and 0 discards the pending wrap
        step("pre_rst_5", 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 3'd5, 1'b0);
        step("pre_rst_6", 1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 3'd6, 1'b0);
        step("pre_rst_7", 1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 3'd7, 1'b0);
        do_reset("reset_between");
        step("post_rst_0", 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 3'd0, 1'b0);
        step("post_rst_1", 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 3'd1, 1'b0);

        step("drain", 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 3'd1, 1'b0);
        repeat (2) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
